div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle restoring divider for DIV/DIVU, attached to the EX stage. EX raises a start request with latched operands and holds the pipeline until the divider answers with a ready pulse train carrying {remainder, quotient}. That result enters the HI/LO path through the EX/MEM register as ex_hi/ex_lo.

## Interface

**Parameters**
- DATA_W, 32: operand width; the iteration count equals DATA_W.

**Ports**
- clk — in, 1 — rising-edge clock.
- rst — in, 1 — asynchronous, active-low reset (0 = reset).
- signed_div_i — in, 1 — 1 = DIV (two's complement), 0 = DIVU.
- opdata1_i — in, DATA_W — dividend.
- opdata2_i — in, DATA_W — divisor.
- start_i — in, 1 — request; EX holds it high until it sees ready_o.
- annul_i — in, 1 — cancel any in-flight or requested operation.
- result_o — out, 2*DATA_W — {remainder, quotient}; remainder goes to HI, quotient to LO.
- ready_o — out, 1 — result_o valid.

## Operation

**States:** IDLE, BYZERO, ON, END. The encoding is free.

**Internal registers**
- dividend register: 2*DATA_W+1 bits.
- abs-divisor: DATA_W bits.
- iteration count: 6 bits.
- sign flags: q_neg = signed & (op1 MSB ^ op2 MSB); r_neg = signed & op1 MSB.

**IDLE**
- start_i=1 and annul_i=0, divisor==0: go to BYZERO.
- start_i=1 and annul_i=0, divisor!=0: go to ON. Latch abs(op1) (if signed) into dividend[DATA_W:1], zero elsewhere. Latch abs(op2), count=0, and the sign flags.
- Otherwise stay in IDLE.
- ready_o=0, result_o=0.

**ON** (one iteration per cycle)
- diff = dividend[2W:W] − {1'b0, abs_divisor}, computed in W+1 bits.
- diff negative: dividend <= dividend << 1.
- diff non-negative: dividend <= {diff[W-1:0], dividend[W-1:0], 1'b1}.
- count increments. The edge that completes iteration DATA_W transitions to END.
- When leaving ON, quotient = dividend[W-1:0] and remainder = dividend[2W:W+1]. Negate the quotient if q_neg and the remainder if r_neg (two's complement, modulo 2^W).
- annul_i=1 in ON: go to IDLE on the next edge. No ready, result discarded.

**BYZERO**
- Next edge goes to END with quotient=0 and remainder=0.

**END**
- start_i=1 and annul_i=0: ready_o<=1, result_o<={remainder, quotient}, stay in END.
- start_i=0 or annul_i=1: ready_o<=0, result_o<=0, go to IDLE.

**Arithmetic rules**
- Signed 0x80000000 / −1 wraps: quotient 0x80000000, remainder 0.
- Remainder sign follows the dividend (MIPS semantics).

**Reset (rst=0, async)**
- state=IDLE, ready_o=0, result_o=0, all internal registers cleared.
- Takes effect immediately, including mid-division.

## Timing

- E0 is the edge sampling start_i=1 in IDLE.
- Normal division: iterations occur at E1..E32 (DATA_W=32), with E32 entering END. ready_o is high after E33: 34 cycles from start assertion to ready visible.
- Divide-by-zero: E0 to BYZERO, E1 to END, ready_o high after E2.
- ready_o and result_o are registered, never combinational from inputs.
- ready_o stays high and result_o stable every cycle start_i remains high.
- Operands are used only at E0; changes to opdata*_i afterwards have no effect.
- start_i dropping while in ON is ignored. Only annul_i cancels.
- Back-to-back: after return to IDLE, a new start is accepted on the following edge.

## Test plan

- **Unsigned basic:** DIVU 100 / 7, start held → ready_o rises 34 cycles after start; result_o = 0x00000002_0000000E.
- **Signed mixed signs:** DIV −7 / 2 → result_o = 0xFFFFFFFF_FFFFFFFD. DIV 7 / −2 → 0x00000001_FFFFFFFD.
- **Divide by zero:** DIV 5 / 0 → ready_o after 3 cycles with result_o = 0. Dropping start_i → ready_o=0 and result_o=0 on the next edge.
- **Boundaries:**
  - DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
  - DIVU 3 / 10 → 0x00000003_00000000.
- **Annul:** start DIVU 100/7, assert annul_i for 1 cycle at iteration 10 → ready_o never rises. A fresh DIVU 9/3 started next completes with 0x00000000_00000003 at normal latency.
- **Async reset mid-op:** pull rst low at iteration 20 between clock edges → ready_o=0 and result_o=0 immediately. After release, DIVU 50/5 yields 0x00000000_0000000A in 34 cycles.

Source files
------------

// File: rtl/div_unit.sv
// Restoring DIV/DIVU divider: one quotient bit per cycle, ready 34 cycles after start (3 for divide-by-zero).
// The result is held in END and re-presented every cycle start_i stays high; annul_i drops the operation.
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BYZERO,
      S_ON,
      S_END
   } state_t;

   localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

   state_t                state, state_nxt;
   logic [2*DATA_W:0]     dividend;
   logic [DATA_W-1:0]     divisor_abs;
   logic [5:0]            count;
   logic                  q_neg, r_neg;
   logic [2*DATA_W-1:0]   res;

   logic                  start_ok;
   logic                  op1_neg, op2_neg;
   logic [DATA_W-1:0]     op1_abs, op2_abs;
   logic [DATA_W:0]       diff;
   logic [2*DATA_W:0]     dvd_step;
   logic [DATA_W-1:0]     quo_raw, rem_raw, quo_fin, rem_fin;
   logic                  ready_nxt;
   logic [2*DATA_W-1:0]   result_nxt;

   always_comb begin
      start_ok = start_i & ~annul_i;
      op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
      op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
      op1_abs  = op1_neg ? -opdata1_i : opdata1_i;
      op2_abs  = op2_neg ? -opdata2_i : opdata2_i;

      // Partial remainder sits in dividend[2W:W+1]; dividend[W] is the next dividend bit.
      diff     = dividend[2*DATA_W:DATA_W] - {1'b0, divisor_abs};
      dvd_step = diff[DATA_W] ? {dividend[2*DATA_W-1:0], 1'b0}
                              : {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};

      // Same bits as dvd_step[W-1:0] and dvd_step[2W:W+1], taken from their sources.
      quo_raw  = {dividend[DATA_W-2:0], ~diff[DATA_W]};
      rem_raw  = diff[DATA_W] ? dividend[2*DATA_W-1:DATA_W] : diff[DATA_W-1:0];
      quo_fin  = q_neg ? -quo_raw : quo_raw;
      rem_fin  = r_neg ? -rem_raw : rem_raw;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ready_nxt  = 1'b0;
      result_nxt = '0;
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
            end
         end
         S_BYZERO: begin
            state_nxt = annul_i ? S_IDLE : S_END;
         end
         S_ON: begin
            if (annul_i) begin
               state_nxt = S_IDLE;
            end else if (count == LAST_ITER) begin
               state_nxt = S_END;
            end
         end
         S_END: begin
            if (start_ok) begin
               ready_nxt  = 1'b1;
               result_nxt = res;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dividend    <= '0;
         divisor_abs <= '0;
         count       <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         res         <= '0;
         ready_o     <= 1'b0;
         result_o    <= '0;
      end else begin
         ready_o  <= ready_nxt;
         result_o <= result_nxt;
         case (state)
            S_IDLE: begin
               if (start_ok && opdata2_i != '0) begin
                  dividend    <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
                  divisor_abs <= op2_abs;
                  count       <= '0;
                  q_neg       <= op1_neg ^ op2_neg;
                  r_neg       <= op1_neg;
               end
            end
            S_BYZERO: begin
               res <= '0;
            end
            S_ON: begin
               if (!annul_i) begin
                  dividend <= dvd_step;
                  count    <= count + 6'd1;
                  if (count == LAST_ITER) begin
                     res <= {rem_fin, quo_fin};
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized divisions against div_unit with a queue of expected results.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        signed_div = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic        start = 1'b0;
   logic        annul = 1'b0;
   logic [63:0] result;
   logic        ready;

   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_q[$];

   div_unit #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst_n),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb, sq, sr;
      if (b == 32'd0) return 64'd0;
      if (!sgn) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
   endfunction

   // Starts one division just after a rising edge and follows it to the start drop.
   task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
      logic [63:0] e;
      int          cyc;
      exp_q.push_back(exp);
      signed_div = sgn;
      op1        = a;
      op2        = b;
      start      = 1'b1;
      cyc        = 0;
      for (int i = 1; i <= lat + 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) begin
            op1 = $urandom;
            op2 = $urandom;
         end
         if (ready) begin
            cyc = i;
            break;
         end
      end
      check({tag, " latency"}, 64'(cyc), 64'(lat));
      e = exp_q.pop_front();
      check({tag, " result"}, result, e);
      @(posedge clk);
      #1;
      check({tag, " hold ready"}, 64'(ready), 64'd1);
      check({tag, " hold result"}, result, e);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " drop ready"}, 64'(ready), 64'd0);
      check({tag, " drop result"}, result, 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          seen;

      #12;
      check("reset ready", 64'(ready), 64'd0);
      check("reset result", result, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
      run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
      run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 34);
      run_div("div 5/0", 1'b1, 32'd5, 32'd0, 64'd0, 3);
      run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);
      run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 34);
      run_div("divu 3/10", 1'b0, 32'd3, 32'd10, 64'h00000003_00000000, 34);
      run_div("divu max/max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000000_00000001, 34);

      for (int k = 0; k < 4; k++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 28);
         if (rb == 32'd0) rb = 32'd3;
         if (k[0] && rb == 32'hFFFF_FFFF) rb = 32'd5;
         run_div($sformatf("rand%0d", k), k[0], ra, rb, model(k[0], ra, rb), 34);
      end

      // Annul at iteration 10: the flushing EX drops start along with annul.
      signed_div = 1'b0;
      op1        = 32'd100;
      op2        = 32'd7;
      start      = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      annul = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (ready) seen = 1'b1;
      end
      check("annul no ready", 64'(seen), 64'd0);
      run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

      // Reset at iteration 20, between edges.
      op1   = 32'd100;
      op2   = 32'd7;
      start = 1'b1;
      repeat (21) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid-op reset ready", 64'(ready), 64'd0);
      check("mid-op reset result", result, 64'd0);
      start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_div("divu 50/5 after reset", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 34);

      // Reset while a result is being presented clears the outputs without waiting for an edge.
      signed_div = 1'b0;
      op1        = 32'd77;
      op2        = 32'd0;
      start      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("byzero ready before reset", 64'(ready), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("end reset ready", 64'(ready), 64'd0);
      start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
